// File: rtl/mem_port_arbiter_if.sv
// Core/memory-side signal bundle of the shared memory port arbiter.
// slave = arbiter view, master = core datapath plus memory macro view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 19
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid,
             mem_en, mem_we, mem_addr, mem_wdata, stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid,
             mem_en, mem_we, mem_addr, mem_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// DM-over-IF arbiter for the shared memory: request to valid in WAIT_CYCLES+2 cycles, stall held while a request waits.
// Optional macro MEM_ARB_STARVE_GUARD_EN forces an IF grant after STARVE_LIMIT back-to-back DM grants.
module mem_port_arbiter #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 19,
   parameter int WAIT_CYCLES = 2
`ifdef MEM_ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 4
`endif
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_t            state_q, state_d;
   owner_t            owner_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              grant_dm;
   logic              grant_if;
   logic              force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q;

   assign force_if = bus.if_req && (starve_q == SW'(STARVE_LIMIT));

   // Counts only DM grants that actually made IF wait; never exceeds the limit
   // because reaching it forces the next grant to IF, which clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else if (grant_if) begin
         starve_q <= '0;
      end else if (grant_dm) begin
         starve_q <= bus.if_req ? starve_q + SW'(1) : '0;
      end
   end
`else
   assign force_if = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      grant_dm = 1'b0;
      grant_if = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.dm_req && !force_if) grant_dm = 1'b1;
            else if (bus.if_req)         grant_if = 1'b1;
            if (grant_dm || grant_if) state_d = BUSY;
         end
         BUSY:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q    <= OWN_NONE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (grant_dm) begin
            owner_q <= OWN_DM;
            addr_q  <= bus.dm_addr;
            we_q    <= bus.dm_we;
            wdata_q <= bus.dm_wdata;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
         end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= bus.if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
         end
         if (state_q == BUSY) begin
            if (cnt_q == '0) begin
               // Read data is only guaranteed in the last enabled cycle.
               if (owner_q == OWN_IF)           if_rdata_q <= bus.mem_rdata;
               if (owner_q == OWN_DM && !we_q)  dm_rdata_q <= bus.mem_rdata;
            end else begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
         end
         if (state_q == DONE) owner_q <= OWN_NONE;
      end
   end

   assign bus.mem_en    = (state_q == BUSY);
   assign bus.mem_we    = (state_q == BUSY) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_valid  = (state_q == DONE) && (owner_q == OWN_IF);
   assign bus.dm_valid  = (state_q == DONE) && (owner_q == OWN_DM);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.stall     = (bus.if_req && !bus.if_valid) || (bus.dm_req && !bus.dm_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model checked every cycle.
module tb_mem_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 19;
   localparam int W  = 2;
   localparam int SL = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 12'h010) return 19'h1ABCD;
      return {a[6:0], a} ^ 19'h2A5A5;
   endfunction

   // Memory macro: combinational read, write on the edge while enabled.
   bit          mem_vld [0:4095];
   logic [DW-1:0] mem_dat [0:4095];
   assign bus.mem_rdata = mem_vld[bus.mem_addr] ? mem_dat[bus.mem_addr] : init_word(bus.mem_addr);
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         mem_vld[bus.mem_addr] <= 1'b1;
         mem_dat[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: an access granted in cycle g owns the memory in cycles
   // g+1..g+W+1 and completes in cycle g+W+2; arbitration resumes at g+W+3.
   bit            m_act = 0;
   int            m_ph  = 0;
   bit            m_dm  = 0;
   bit            m_we  = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wd   = '0;
   logic [DW-1:0] e_ifr  = '0;
   logic [DW-1:0] e_dmr  = '0;
   int            starve = 0;
   bit            ref_vld [0:4095];
   logic [DW-1:0] ref_dat [0:4095];

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_vld[a] ? ref_dat[a] : init_word(a);
   endfunction

   always @(negedge clk) begin : model
      bit e_en, e_we, e_ifv, e_dmv, e_stall, force_if;
      e_en    = m_act && m_ph >= 1 && m_ph <= W + 1;
      e_we    = e_en && m_dm && m_we;
      e_ifv   = m_act && m_ph == W + 2 && !m_dm;
      e_dmv   = m_act && m_ph == W + 2 && m_dm;
      e_stall = (bus.if_req && !e_ifv) || (bus.dm_req && !e_dmv);
      chk("mem_en",   32'(bus.mem_en),   32'(e_en));
      chk("mem_we",   32'(bus.mem_we),   32'(e_we));
      if (e_en) chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
      if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
      chk("if_valid", 32'(bus.if_valid), 32'(e_ifv));
      chk("dm_valid", 32'(bus.dm_valid), 32'(e_dmv));
      chk("if_rdata", 32'(bus.if_rdata), 32'(e_ifr));
      chk("dm_rdata", 32'(bus.dm_rdata), 32'(e_dmr));
      chk("stall",    32'(bus.stall),    32'(e_stall));
      if (e_we) begin
         ref_vld[m_addr] = 1'b1;
         ref_dat[m_addr] = m_wd;
      end
      if (rst) begin
         m_act = 0; m_ph = 0; m_we = 0; m_addr = '0;
         e_ifr = '0; e_dmr = '0; starve = 0;
      end else if (m_act) begin
         if (m_ph == W + 1 && !m_we) begin
            if (m_dm) e_dmr = ref_rd(m_addr);
            else      e_ifr = ref_rd(m_addr);
         end
         if (m_ph == W + 2) m_act = 0;
         else               m_ph++;
      end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         force_if = bus.if_req && starve >= SL;
`else
         force_if = 0;
`endif
         if (bus.dm_req && !force_if) begin
            starve = bus.if_req ? starve + 1 : 0;
            m_act = 1; m_ph = 1; m_dm = 1; m_we = bus.dm_we;
            m_addr = bus.dm_addr; m_wd = bus.dm_wdata;
         end else if (bus.if_req) begin
            starve = 0;
            m_act = 1; m_ph = 1; m_dm = 0; m_we = 0;
            m_addr = bus.if_addr;
         end
      end
   end

   logic          en_log   [0:63];
   logic          we_log   [0:63];
   logic          st_log   [0:63];
   logic [AW-1:0] addr_log [0:63];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raises the selected requests in cycle 0 and drops each one the cycle after its valid.
   task automatic run(input bit use_dm, input bit use_if, input bit we,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [AW-1:0] ia,
                      input int chg_cyc, input logic [AW-1:0] chg_addr,
                      output int dm_at, output int if_at);
      dm_at = -1;
      if_at = -1;
      tick();
      bus.dm_req = use_dm; bus.dm_we = we; bus.dm_addr = da; bus.dm_wdata = wd;
      bus.if_req = use_if; bus.if_addr = ia;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         en_log[c] = bus.mem_en; we_log[c] = bus.mem_we;
         st_log[c] = bus.stall;  addr_log[c] = bus.mem_addr;
         if (bus.dm_valid && dm_at < 0) dm_at = c;
         if (bus.if_valid && if_at < 0) if_at = c;
         if ((!use_dm || dm_at >= 0) && (!use_if || if_at >= 0)) break;
         tick();
         if (dm_at >= 0) bus.dm_req = 1'b0;
         if (if_at >= 0) bus.if_req = 1'b0;
         if (c + 1 == chg_cyc) bus.dm_addr = chg_addr;
      end
      tick();
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;
   endtask

   initial begin : stim
      int dm_at, if_at, nwe, k;
      bit seq [0:5];
      bit exp_seq [0:5];
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst mem_en",    32'(bus.mem_en),    0);
      chk("rst mem_we",    32'(bus.mem_we),    0);
      chk("rst if_valid",  32'(bus.if_valid),  0);
      chk("rst dm_valid",  32'(bus.dm_valid),  0);
      chk("rst mem_addr",  32'(bus.mem_addr),  0);
      chk("rst mem_wdata", 32'(bus.mem_wdata), 0);
      chk("rst if_rdata",  32'(bus.if_rdata),  0);
      chk("rst dm_rdata",  32'(bus.dm_rdata),  0);
      tick();
      rst = 1'b0;

      // Single fetch
      run(0, 1, 0, '0, '0, 12'h010, -1, '0, dm_at, if_at);
      chk("fetch latency", if_at, 4);
      chk("fetch en c0", 32'(en_log[0]), 0);
      for (int c = 1; c <= 3; c++) chk("fetch en busy", 32'(en_log[c]), 1);
      chk("fetch en c4", 32'(en_log[4]), 0);
      chk("fetch we", 32'(we_log[2]), 0);
      chk("fetch stall c0", 32'(st_log[0]), 1);
      chk("fetch stall c3", 32'(st_log[3]), 1);
      chk("fetch stall c4", 32'(st_log[4]), 0);
      chk("fetch rdata", 32'(bus.if_rdata), 32'h1ABCD);

      // Store then load back
      run(1, 0, 1, 12'h020, 19'h00055, '0, -1, '0, dm_at, if_at);
      nwe = 0;
      for (int c = 0; c <= 4; c++) nwe += int'(we_log[c]);
      chk("store latency", dm_at, 4);
      chk("store we cycles", nwe, 3);
      chk("store keeps dm_rdata", 32'(bus.dm_rdata), 0);
      run(1, 0, 0, 12'h020, '0, '0, -1, '0, dm_at, if_at);
      chk("load latency", dm_at, 4);
      chk("load rdata", 32'(bus.dm_rdata), 32'h00055);

      // Simultaneous requests: DM first
      run(1, 1, 0, 12'h100, '0, 12'h200, -1, '0, dm_at, if_at);
      chk("both dm_valid cyc", dm_at, 4);
      chk("both if_valid cyc", if_at, 9);
      chk("both en c5", 32'(en_log[5]), 0);
      chk("both if addr c6", 32'(addr_log[6]), 32'h200);

      // Address change while busy is ignored
      run(1, 0, 0, 12'h020, '0, '0, 2, 12'h030, dm_at, if_at);
      chk("chg addr c2", 32'(addr_log[2]), 32'h020);
      chk("chg addr c3", 32'(addr_log[3]), 32'h020);
      chk("chg rdata", 32'(bus.dm_rdata), 32'h00055);

      // Reset in cycle 2 of a fetch
      tick();
      bus.if_req = 1'b1; bus.if_addr = 12'h010;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid en c2", 32'(bus.mem_en), 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid en c3", 32'(bus.mem_en), 0);
      chk("rstmid if_valid c3", 32'(bus.if_valid), 0);
      chk("rstmid if_rdata c3", 32'(bus.if_rdata), 0);
      if_at = -1;
      for (int c = 3; c < 40; c++) begin
         if (c > 3) @(negedge clk);
         if (bus.if_valid) begin
            if_at = c;
            break;
         end
         tick();
      end
      chk("rstmid reserve cyc", if_at, 7);
      chk("rstmid rdata", 32'(bus.if_rdata), 32'h1ABCD);
      tick();
      bus.if_req = 1'b0;

      // DM held with IF waiting
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_seq = '{1, 1, 1, 1, 0, 1};
`else
      exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
      tick();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h040;
      bus.if_req = 1'b1; bus.if_addr = 12'h050;
      k = 0;
      if_at = -1;
      for (int c = 0; c < 80 && k < 6; c++) begin
         @(negedge clk);
         if (bus.dm_valid) begin seq[k] = 1; k++; end
         if (bus.if_valid) begin seq[k] = 0; k++; if_at = c; end
         tick();
         if (if_at >= 0) bus.if_req = 1'b0;
      end
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;
      chk("held grants", k, 6);
      for (int i = 0; i < 6; i++) chk("held order", 32'(seq[i]), 32'(exp_seq[i]));
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve if cyc", if_at, 24);
`else
      chk("strict no if", if_at, -1);
`endif

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between two requesters: instruction fetch (IF) and data access (DM, issued by LDM/STM).
- Fixed-priority arbiter with a multi-cycle access sequencer that supports a configurable number of memory wait states.
- Drives a stall line to the PC/pipeline logic while any request is outstanding.
- Sits between the core datapath and the memory macro.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 19, memory word width (instruction word width)
WAIT_CYCLES, 2, extra cycles mem_en is held beyond the first (0 = single-cycle access)
STARVE_LIMIT, 4, consecutive DM grants tolerated while IF waits (used only with optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request, level, held until if_valid
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched word, registered
if_valid  output  1  one-cycle completion pulse for fetch
dm_req  input  1  data request, level, held until dm_valid
dm_we  input  1  1 = store (STM), 0 = load (LDM)
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_rdata  output  DATA_W  load data, registered
dm_valid  output  1  one-cycle completion pulse for data access
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in final access cycle
stall  output  1  combinational: (if_req & ~if_valid) | (dm_req & ~dm_valid)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. One clock domain.
- Reset values: state IDLE, owner none, wait counter 0. mem_en, mem_we, if_valid, dm_valid all 0. mem_addr, mem_wdata, if_rdata, dm_rdata all 0.
- Reset mid-access: the next edge returns to IDLE and mem_en drops. The in-flight access is abandoned and no valid pulse is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If dm_req, grant DM; else if if_req, grant IF; else stay in IDLE.
  - DM wins when both requests are high.
  - On grant, register the owner, address, we and wdata. Later input changes are ignored until DONE.
  - Load counter with WAIT_CYCLES and go to BUSY.
- BUSY:
  - mem_en=1, mem_addr/mem_we/mem_wdata driven from the registered values.
  - mem_we is 1 only for a DM store; IF is always a read.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata into the owner's rdata register (loads and fetches only) and go to DONE.
  - Total mem_en high time is WAIT_CYCLES+1 cycles.
- DONE:
  - Owner's valid=1 for exactly one cycle. mem_en=0.
  - Both req inputs are ignored in this cycle. Go to IDLE.
  - The requester must deassert req by the end of the valid cycle.
- Latency: req seen in IDLE at cycle 0 → valid in cycle WAIT_CYCLES+2 (default: cycle 4). The next arbitration happens in cycle WAIT_CYCLES+3.
- Stores: dm_valid pulses and dm_rdata holds its previous value.
- rdata registers hold their value until the next completion on the same port.
- WAIT_CYCLES=0: BUSY lasts one cycle.
- Never more than one access outstanding. mem_en is never high in IDLE or DONE.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro:
  - A starvation counter increments on each DM grant made while if_req is high.
  - When the counter reaches STARVE_LIMIT, the next IDLE arbitration grants IF even if dm_req is high.
  - The counter clears on any IF grant, and on any DM grant made while if_req is low.
  - The counter resets to 0.
- Without the macro: strict DM priority; no counter logic is present.

Test Plan:
- Single fetch: if_req=1, if_addr=0x010, memory word 0x1ABCD, WAIT_CYCLES=2 → mem_en high cycles 1-3, mem_we=0, if_valid and if_rdata=0x1ABCD in cycle 4, stall high cycles 0-3.
- Store then load: dm_req with we=1, addr=0x020, wdata=0x00055, then a load from 0x020 → mem_we high for 3 cycles, first dm_valid in cycle 4, dm_rdata unchanged; second dm_valid with dm_rdata=0x00055.
- Simultaneous requests: if_req and dm_req both rise in cycle 0 → DM served (dm_valid cycle 4), IF granted cycle 5, if_valid cycle 9.
- Reset mid-access: rst asserted in cycle 2 of a fetch → cycle 3 mem_en=0, state IDLE, no if_valid ever; the request is re-served after reset is released.
- Input change during BUSY: dm_addr changed 0x020→0x030 in cycle 2 → mem_addr stays 0x020 through cycle 3.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dm_req held high and if_req high → 4 DM accesses, then IF is granted on the 5th arbitration, then DM resumes.
